// File: rtl/dbus_arb.sv
// dbus_arb: two-master arbiter for the SoC data bus with a registered grant FSM.
// Optional build macro DBUS_ARB_TIMEOUT_EN adds a per-grant watchdog and a sticky err flag.
module dbus_arb #(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        a_cyc,
  input  logic        a_we,
  input  logic [3:0]  a_sel,
  input  logic [31:0] a_adr,
  input  logic [31:0] a_dat,
  output logic        a_ack,
  output logic [31:0] a_rdt,
  input  logic        b_cyc,
  input  logic        b_we,
  input  logic [3:0]  b_sel,
  input  logic [31:0] b_adr,
  input  logic [31:0] b_dat,
  output logic        b_ack,
  output logic [31:0] b_rdt,
  output logic        x_cyc,
  output logic        x_we,
  output logic [3:0]  x_sel,
  output logic [31:0] x_adr,
  output logic [31:0] x_dat,
  input  logic        x_ack,
  input  logic [31:0] x_rdt,
  output logic        owner,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t state;
  logic   last;      // master served most recently: 0 = A, 1 = B
  logic   tmo;
  logic   owner_cyc;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TERM = 8'(TIMEOUT);
  logic [7:0] cnt;
  assign tmo = busy && (cnt == TERM);
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign x_cyc     = busy;
  assign owner_cyc = owner ? b_cyc : a_cyc;

  // NOTE: ack/rdt are combinational from x_ack so the owner sees the slave's ack in the same cycle.
  assign a_ack = (state == GRANT_A) && (x_ack || tmo);
  assign b_ack = (state == GRANT_B) && (x_ack || tmo);
  assign a_rdt = ((state == GRANT_A) && x_ack) ? x_rdt : '0;
  assign b_rdt = ((state == GRANT_B) && x_ack) ? x_rdt : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    x_we  = 1'b0;
    x_sel = '0;
    x_adr = '0;
    x_dat = '0;
    if (state == GRANT_A) begin
      x_we  = a_we;
      x_sel = a_sel;
      x_adr = a_adr;
      x_dat = a_dat;
    end else if (state == GRANT_B) begin
      x_we  = b_we;
      x_sel = b_sel;
      x_adr = b_adr;
      x_dat = b_dat;
    end
  end

  // NOTE: state is updated with non-blocking assignments only; reset is synchronous to wb_clk.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
`ifdef DBUS_ARB_TIMEOUT_EN
      cnt   <= '0;
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A wins alone, on fixed priority, or when B was served last.
          if (a_cyc && (!b_cyc || !ROUND_ROBIN || last)) begin
            state <= GRANT_A;
            owner <= 1'b0;
`ifdef DBUS_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else if (b_cyc) begin
            state <= GRANT_B;
            owner <= 1'b1;
`ifdef DBUS_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        default: begin
          if (x_ack || tmo) begin
            state <= IDLE;
            last  <= owner;
`ifdef DBUS_ARB_TIMEOUT_EN
            if (!x_ack) err <= 1'b1;
`endif
          end else if (!owner_cyc) begin
            state <= IDLE;
          end else begin
`ifdef DBUS_ARB_TIMEOUT_EN
            cnt <= cnt + 8'd1;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arb.sv
// Bench for dbus_arb: fixed-priority and round-robin instances side by side, directed
// steps followed by random traffic, all compared against a transaction-level model.
module tb_dbus_arb;

  localparam int TMO   = 16;
  localparam int NEVER = 1000;
`ifdef DBUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_cyc[2], a_we[2], b_cyc[2], b_we[2];
  logic [3:0]  a_sel[2], b_sel[2];
  logic [31:0] a_adr[2], a_dat[2], b_adr[2], b_dat[2];
  logic        a_ack[2], b_ack[2];
  logic [31:0] a_rdt[2], b_rdt[2];
  logic        x_cyc[2], x_we[2], x_ack[2];
  logic [3:0]  x_sel[2];
  logic [31:0] x_adr[2], x_dat[2], x_rdt[2];
  logic        owner[2], busy[2], err[2];

  // Instance 0: fixed priority; instance 1: round robin.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    dbus_arb #(.ROUND_ROBIN(1'(g)), .TIMEOUT(TMO)) u_dut (
      .wb_clk(clk), .wb_rst(rst),
      .a_cyc(a_cyc[g]), .a_we(a_we[g]), .a_sel(a_sel[g]), .a_adr(a_adr[g]), .a_dat(a_dat[g]),
      .a_ack(a_ack[g]), .a_rdt(a_rdt[g]),
      .b_cyc(b_cyc[g]), .b_we(b_we[g]), .b_sel(b_sel[g]), .b_adr(b_adr[g]), .b_dat(b_dat[g]),
      .b_ack(b_ack[g]), .b_rdt(b_rdt[g]),
      .x_cyc(x_cyc[g]), .x_we(x_we[g]), .x_sel(x_sel[g]), .x_adr(x_adr[g]), .x_dat(x_dat[g]),
      .x_ack(x_ack[g]), .x_rdt(x_rdt[g]),
      .owner(owner[g]), .busy(busy[g]), .err(err[g])
    );
  end

  typedef struct {
    bit        pend;
    bit        we;
    bit [3:0]  sel;
    bit [31:0] adr;
    bit [31:0] dat;
  } req_t;

  req_t ma[2], mb[2];
  // Model: who holds the bus (0 none, 1 A, 2 B), who was served last, grant age.
  int   m_gnt[2], m_last[2], m_own[2], m_cnt[2], lat[2];
  bit   m_err[2];
  bit   rnd, spur, fix_rdt_en;
  logic [31:0] fix_rdt;
  int   ord[2];
  int   errors, checks;

  logic        obs_xcyc[2], obs_aack[2], obs_back[2], obs_owner[2], obs_busy[2], obs_err[2], obs_we[2];
  logic [3:0]  obs_sel[2];
  logic [31:0] obs_ardt[2], obs_adr[2], obs_dat[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit is_b, input bit we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
    for (int k = 0; k < 2; k++) begin
      if (is_b) mb[k] = '{1'b1, we, sel, adr, dat};
      else      ma[k] = '{1'b1, we, sel, adr, dat};
    end
  endtask

  task automatic rand_req(inout req_t r);
    r.pend = 1'b1;
    r.we   = 1'($urandom);
    r.sel  = 4'($urandom);
    r.adr  = $urandom;
    r.dat  = $urandom;
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      a_cyc[k] = ma[k].pend; a_we[k] = ma[k].we; a_sel[k] = ma[k].sel;
      a_adr[k] = ma[k].adr;  a_dat[k] = ma[k].dat;
      b_cyc[k] = mb[k].pend; b_we[k] = mb[k].we; b_sel[k] = mb[k].sel;
      b_adr[k] = mb[k].adr;  b_dat[k] = mb[k].dat;
      if (m_gnt[k] != 0) x_ack[k] = (m_cnt[k] == lat[k]);
      else               x_ack[k] = spur && ($urandom_range(9) == 0);
      x_rdt[k] = fix_rdt_en ? fix_rdt : $urandom;
    end
  endtask

  task automatic eval();
    for (int k = 0; k < 2; k++) begin
      string p;
      bit ga, gb, bz, tmo, ea, eb, ycyc;
      int win;
      logic [31:0] ex_adr, ex_dat;
      logic [3:0]  ex_sel;
      logic        ex_we;
      p   = $sformatf("i%0d@%0t ", k, $time);
      ga  = (m_gnt[k] == 1);
      gb  = (m_gnt[k] == 2);
      bz  = ga || gb;
      tmo = TO_EN && bz && (m_cnt[k] == TMO);
      ea  = ga && (x_ack[k] || tmo);
      eb  = gb && (x_ack[k] || tmo);
      ex_we  = ga ? a_we[k]  : gb ? b_we[k]  : 1'b0;
      ex_sel = ga ? a_sel[k] : gb ? b_sel[k] : 4'h0;
      ex_adr = ga ? a_adr[k] : gb ? b_adr[k] : 32'h0;
      ex_dat = ga ? a_dat[k] : gb ? b_dat[k] : 32'h0;
      check({p, "x_cyc"}, 32'(x_cyc[k]), 32'(bz));
      check({p, "busy"},  32'(busy[k]),  32'(bz));
      check({p, "owner"}, 32'(owner[k]), 32'(m_own[k]));
      check({p, "x_we"},  32'(x_we[k]),  32'(ex_we));
      check({p, "x_sel"}, 32'(x_sel[k]), 32'(ex_sel));
      check({p, "x_adr"}, x_adr[k], ex_adr);
      check({p, "x_dat"}, x_dat[k], ex_dat);
      check({p, "a_ack"}, 32'(a_ack[k]), 32'(ea));
      check({p, "b_ack"}, 32'(b_ack[k]), 32'(eb));
      check({p, "a_rdt"}, a_rdt[k], (ga && x_ack[k]) ? x_rdt[k] : 32'h0);
      check({p, "b_rdt"}, b_rdt[k], (gb && x_ack[k]) ? x_rdt[k] : 32'h0);
      check({p, "err"},   32'(err[k]), 32'(m_err[k]));
      obs_xcyc[k] = x_cyc[k]; obs_aack[k] = a_ack[k]; obs_back[k] = b_ack[k];
      obs_owner[k] = owner[k]; obs_busy[k] = busy[k]; obs_err[k] = err[k];
      obs_we[k] = x_we[k]; obs_sel[k] = x_sel[k]; obs_adr[k] = x_adr[k];
      obs_dat[k] = x_dat[k]; obs_ardt[k] = a_rdt[k];
      if (a_ack[k] === 1'b1) ord[k] = ord[k] * 10 + 1;
      if (b_ack[k] === 1'b1) ord[k] = ord[k] * 10 + 2;

      if (rst) begin
        m_gnt[k] = 0; m_last[k] = 1; m_own[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
        ma[k].pend = 1'b0; mb[k].pend = 1'b0;
      end else begin
        if (!bz) begin
          if (ma[k].pend && mb[k].pend) win = (k == 0) ? 1 : ((m_last[k] == 0) ? 2 : 1);
          else win = ma[k].pend ? 1 : (mb[k].pend ? 2 : 0);
          if (win != 0) begin
            m_gnt[k] = win; m_own[k] = win - 1; m_cnt[k] = 0;
            if (rnd) lat[k] = $urandom_range(TO_EN ? 20 : 4);
          end
        end else begin
          ycyc = gb ? b_cyc[k] : a_cyc[k];
          if (x_ack[k] || tmo) begin
            if (!x_ack[k]) m_err[k] = 1'b1;
            m_last[k] = m_gnt[k] - 1;
            m_gnt[k]  = 0;
          end else if (!ycyc) begin
            m_gnt[k] = 0;
          end else begin
            m_cnt[k]++;
          end
        end
        if (ea) ma[k].pend = 1'b0;
        if (eb) mb[k].pend = 1'b0;
        if (rnd) begin
          if (!ma[k].pend && $urandom_range(9) < 3) rand_req(ma[k]);
          else if (ma[k].pend && $urandom_range(99) < 3) ma[k].pend = 1'b0;
          if (!mb[k].pend && $urandom_range(9) < 3) rand_req(mb[k]);
          else if (mb[k].pend && $urandom_range(99) < 3) mb[k].pend = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    eval();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    errors = 0; checks = 0;
    rnd = 1'b0; spur = 1'b0; fix_rdt_en = 1'b1; fix_rdt = 32'h0;
    for (int k = 0; k < 2; k++) begin
      ma[k] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
      mb[k] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
      m_gnt[k] = 0; m_last[k] = 1; m_own[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
      lat[k] = 1; ord[k] = 0;
    end
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    cycle();
    check("rst_busy", 32'(obs_busy[0]), 32'h0);
    check("rst_owner", 32'(obs_owner[1]), 32'h0);

    // A read, slave acks one cycle after x_cyc.
    fix_rdt = 32'h1234_5678;
    issue(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    cycle();
    check("rd_xcyc_n", 32'(obs_xcyc[0]), 32'h0);
    cycle();
    check("rd_xcyc_n1", 32'(obs_xcyc[0]), 32'h1);
    check("rd_aack_n1", 32'(obs_aack[0]), 32'h0);
    cycle();
    check("rd_aack_n2", 32'(obs_aack[0]), 32'h1);
    check("rd_ardt_n2", obs_ardt[0], 32'h1234_5678);
    check("rd_back_n2", 32'(obs_back[0]), 32'h0);
    cycle();
    check("rd_xcyc_n3", 32'(obs_xcyc[0]), 32'h0);

    // Two collisions: fixed priority serves A then B; round robin alternates from last=A.
    for (int r = 0; r < 2; r++) begin
      ord[0] = 0; ord[1] = 0;
      issue(1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
      issue(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
      repeat (8) cycle();
      check($sformatf("coll%0d_fixed_order", r), ord[0], 12);
      check($sformatf("coll%0d_rr_order", r), ord[1], 21);
    end

    // B write mirrored onto the peripheral bus.
    lat[0] = 2; lat[1] = 2;
    issue(1'b1, 1'b1, 4'hF, 32'hC000_0008, 32'hAA55_AA55);
    cycle();
    cycle();
    check("bwr_adr", obs_adr[0], 32'hC000_0008);
    check("bwr_dat", obs_dat[0], 32'hAA55_AA55);
    check("bwr_sel", 32'(obs_sel[0]), 32'hF);
    check("bwr_we", 32'(obs_we[0]), 32'h1);
    check("bwr_owner", 32'(obs_owner[0]), 32'h1);
    check("bwr_aack", 32'(obs_aack[0]), 32'h0);
    repeat (4) cycle();

    // Reset pulsed mid-grant, then a normal A transfer.
    lat[0] = NEVER; lat[1] = NEVER;
    issue(1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
    cycle();
    cycle();
    check("rstg_busy_before", 32'(obs_busy[0]), 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("rstg_busy_after", 32'(obs_busy[0]), 32'h0);
    check("rstg_xcyc_after", 32'(obs_xcyc[0]), 32'h0);
    check("rstg_back_after", 32'(obs_back[0]), 32'h0);
    ord[0] = 0;
    lat[0] = 1; lat[1] = 1;
    issue(1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    repeat (4) cycle();
    check("rstg_a_served", ord[0], 1);

`ifdef DBUS_ARB_TIMEOUT_EN
    // Unmapped read: forced ack with zero data TMO cycles after grant, sticky err.
    lat[0] = NEVER; lat[1] = NEVER;
    issue(1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'h0);
    n = -1;
    for (int i = 0; i < 40 && n < 0; i++) begin
      cycle();
      if (obs_aack[0] === 1'b1) begin
        n = i;
        check("tmo_ardt", obs_ardt[0], 32'h0);
      end
    end
    check("tmo_ack_cycle", n, TMO + 1);
    repeat (3) cycle();
    check("tmo_err_sticky", 32'(obs_err[0]), 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("tmo_err_cleared", 32'(obs_err[0]), 32'h0);
`else
    n = 0;
`endif

    // Random traffic: spurious idle acks, aborts, random latency and occasional resets.
    rnd = 1'b1; spur = 1'b1; fix_rdt_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
